// File: rtl/lsm_sequencer.sv
// ---------------------------------------------------------------------------
// lsm_sequencer
//   Multi-cycle sequencer for Load/Store Multiple. The decoder launches it
//   with start. It walks the 16-bit register list from the lowest set bit to
//   the highest and issues one word transfer per set bit. It generates the
//   memory address and register index for each beat, then produces the base
//   writeback value.
//
//   Optional feature macro: LSM_USER_BANK_EN
//     defined   : user_bank is raised during XFER when S=1, except for a
//                 load that has R15 in the list.
//     undefined : user_bank is tied to 0 and S is ignored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch; only sampled while idle
//   instr             P[24] U[23] S[22] W[21] L[20] Rn[19:16] list[15:0]
//   base_val          value of Rn, captured together with start
//   mem_ready         memory accepted the current beat
//   mem_rdata         load data, valid while mem_ready=1
//   rf_rdata          register-file read data (store source)
//   busy              from the cycle after start until DONE exits
//   mem_req/mem_we    beat request / 1=store
//   mem_addr          word address of the current beat
//   mem_wdata         store data (pass-through of rf_rdata)
//   rf_idx            register of the current beat
//   rf_we/rf_wdata    load writeback into the register file
//   wb_en/wb_idx/wb_val  base writeback strobe, register and value
//   user_bank         force the user-mode register bank
//   done              one-cycle completion pulse
// ---------------------------------------------------------------------------
module lsm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int WORD_B = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] base_val,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       rf_rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        rf_idx,
    output logic              rf_we,
    output logic [31:0]       rf_wdata,
    output logic              wb_en,
    output logic [3:0]        wb_idx,
    output logic [ADDR_W-1:0] wb_val,
    output logic              user_bank,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_B);

    state_t            state, state_nx;
    logic [24:0]       instr_q;   // control fields and original list
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_val_q;
    logic [15:0]       pend_q;    // registers still to be transferred

    // Latched instruction fields
    logic        f_p, f_u, f_w, f_l;
    logic [3:0]  f_rn;
    logic [15:0] f_list;

    assign f_p    = instr_q[24];
    assign f_u    = instr_q[23];
    assign f_w    = instr_q[21];
    assign f_l    = instr_q[20];
    assign f_rn   = instr_q[19:16];
    assign f_list = instr_q[15:0];

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // The loop runs from the top down, so the last hit is the lowest set bit.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // -----------------------------------------------------------------------
    // SETUP arithmetic: span = N * WORD_B. Everything wraps mod 2^ADDR_W.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] final_base;

    assign span = ADDR_W'(popcount16(f_list)) * STEP;

    always_comb begin
        start_addr = base_q;
        unique case ({f_p, f_u})
            2'b01: start_addr = base_q;                 // IA
            2'b11: start_addr = base_q + STEP;          // IB
            2'b00: start_addr = base_q - span + STEP;   // DA
            2'b10: start_addr = base_q - span;          // DB
            default: start_addr = base_q;
        endcase
    end

    assign final_base = f_u ? (base_q + span) : (base_q - span);

    // The last beat is the one where only a single pending bit remains.
    logic last_beat;
    assign last_beat = (pend_q & (pend_q - 16'd1)) == 16'd0;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_SETUP;
            S_SETUP: state_nx = (f_list == 16'd0) ? S_DONE : S_XFER;
            S_XFER:  if (mem_ready && last_beat) state_nx = f_w ? S_WB : S_DONE;
            S_WB:    state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            wb_val_q <= '0;
            pend_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        instr_q <= instr[24:0];
                        base_q  <= base_val;
                        pend_q  <= instr[15:0];
                    end
                end
                S_SETUP: begin
                    addr_q   <= start_addr;
                    wb_val_q <= final_base;
                end
                S_XFER: begin
                    if (mem_ready) begin
                        addr_q <= addr_q + STEP;
                        pend_q <= pend_q & (pend_q - 16'd1);   // clear lowest set bit
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy      = (state != S_IDLE);
    assign mem_req   = (state == S_XFER);
    assign mem_we    = mem_req & ~f_l;
    assign mem_addr  = addr_q;
    assign mem_wdata = rf_rdata;
    assign rf_idx    = lowest_set(pend_q);
    assign rf_we     = mem_req & mem_ready & f_l;
    assign rf_wdata  = mem_rdata;
    // A load that includes Rn keeps the loaded value, so the writeback is dropped.
    assign wb_en     = (state == S_WB) & ~(f_l & f_list[f_rn]);
    assign wb_idx    = f_rn;
    assign wb_val    = wb_val_q;
    assign done      = (state == S_DONE);

`ifdef LSM_USER_BANK_EN
    // A load of R15 with S=1 is a mode restore, not a user-bank transfer.
    assign user_bank = mem_req & instr_q[22] & ~(f_l & f_list[15]);
`else
    assign user_bank = 1'b0;
    logic unused_s;
    assign unused_s = instr_q[22];
`endif

    logic unused_instr;
    assign unused_instr = ^instr[31:25];

endmodule

// File: tb/tb_lsm_sequencer.sv
module tb_lsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic [31:0] base_val;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] rf_rdata;
    logic        busy, mem_req, mem_we, rf_we, wb_en, user_bank, done;
    logic [31:0] mem_addr, mem_wdata, rf_wdata, wb_val;
    logic [3:0]  rf_idx, wb_idx;

    lsm_sequencer #(.ADDR_W(32), .WORD_B(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .base_val(base_val), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rf_rdata(rf_rdata), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rf_idx(rf_idx),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .wb_en(wb_en), .wb_idx(wb_idx),
        .wb_val(wb_val), .user_bank(user_bank), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  idx;
        logic        we;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lsm(input logic p, input logic u, input logic s,
                                        input logic w, input logic l,
                                        input logic [3:0] rn, input logic [15:0] list);
        return {4'hE, 3'b100, p, u, s, w, l, rn, list};
    endfunction

    task automatic push(input logic [31:0] a, input logic [3:0] i, input logic we);
        beat_t b;
        b.addr = a; b.idx = i; b.we = we;
        exp_q.push_back(b);
    endtask

    // Runs one operation; expected beats are queued by the caller beforehand.
    task automatic run_op(input string name, input logic [31:0] ins, input logic [31:0] base,
                          input int stall, input logic exp_wb, input logic [31:0] exp_wbv,
                          input int exp_done, input logic poke);
        int   wait_cnt;
        int   done_cyc;
        int   first_req;
        int   wb_seen;
        logic [31:0] wbv_seen;
        logic l, s, r15;
        beat_t b;
        l = ins[20]; s = ins[22]; r15 = ins[15];
        wait_cnt = 0; done_cyc = -1; first_req = -1; wb_seen = 0; wbv_seen = '0;

        @(negedge clk);
        start = 1'b1; instr = ins; base_val = base;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1;
                instr = lsm(0, 1, 0, 1, 0, 4'd9, 16'hFFFF);
                base_val = 32'hDEAD_0000;
            end
            if (mem_req) begin
                if (wait_cnt < stall) begin mem_ready = 1'b0; wait_cnt++; end
                else begin mem_ready = 1'b1; wait_cnt = 0; end
            end else begin
                mem_ready = cyc[0];   // stray ready outside a request must be ignored
            end
            rf_rdata  = {28'hA00_0000, rf_idx};
            mem_rdata = mem_addr ^ 32'h5A5A_0000;
            #1;
            if (mem_req) begin
                if (first_req < 0) first_req = cyc;
                if (exp_q.size() == 0) begin
                    chk({name, "_extra_beat"}, 32'(rf_idx), 32'hFFFF_FFFF);
                end else begin
                    b = exp_q[0];
                    chk({name, "_addr"}, mem_addr, b.addr);
                    chk({name, "_idx"}, 32'(rf_idx), 32'(b.idx));
                    chk({name, "_we"}, 32'(mem_we), 32'(b.we));
`ifdef LSM_USER_BANK_EN
                    chk({name, "_ubank"}, 32'(user_bank), 32'(s & ~(l & r15)));
`else
                    chk({name, "_ubank"}, 32'(user_bank), 32'(1'b0 & s & r15));
`endif
                    if (b.we) chk({name, "_wdata"}, mem_wdata, {28'hA00_0000, b.idx});
                    chk({name, "_rf_we"}, 32'(rf_we), 32'(mem_ready & ~b.we));
                    if (mem_ready && !b.we)
                        chk({name, "_rf_wdata"}, rf_wdata, b.addr ^ 32'h5A5A_0000);
                    if (mem_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk({name, "_rf_we_idle"}, 32'(rf_we), 32'h0);
            end
            if (wb_en) begin
                wb_seen++;
                wbv_seen = wb_val;
                chk({name, "_wb_idx"}, 32'(wb_idx), 32'(ins[19:16]));
            end
            chk({name, "_busy"}, 32'(busy), 32'h1);
            if (done) begin done_cyc = cyc; break; end
        end
        start = 1'b0; mem_ready = 1'b0;
        chk({name, "_done_cyc"}, done_cyc, exp_done);
        if (exp_q.size() != 0) begin
            chk({name, "_beats_left"}, exp_q.size(), 0);
            exp_q.delete();
        end
        chk({name, "_wb_count"}, wb_seen, exp_wb ? 1 : 0);
        if (exp_wb) chk({name, "_wb_val"}, wbv_seen, exp_wbv);
        if (exp_done > 2) chk({name, "_first_req"}, first_req, 2);
        else chk({name, "_no_req"}, first_req, -1);
        @(negedge clk); #1;
        chk({name, "_idle_busy"}, 32'(busy), 32'h0);
        chk({name, "_idle_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr = '0; base_val = '0;
        mem_ready = 1'b0; mem_rdata = '0; rf_rdata = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wb", 32'(wb_en), 32'h0);
        chk("rst_wbval", wb_val, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // LDMIA R0!,{R1,R2,R4}
        push(32'h1000, 4'd1, 1'b0); push(32'h1004, 4'd2, 1'b0); push(32'h1008, 4'd4, 1'b0);
        run_op("ldmia", lsm(0, 1, 0, 1, 1, 4'd0, 16'h0016), 32'h1000, 0, 1'b1, 32'h100C, 6, 1'b0);

        // STMDB R13!,{R4-R7,R14} with S=1 (user_bank tracks the build option)
        push(32'h1FEC, 4'd4, 1'b1); push(32'h1FF0, 4'd5, 1'b1); push(32'h1FF4, 4'd6, 1'b1);
        push(32'h1FF8, 4'd7, 1'b1); push(32'h1FFC, 4'd14, 1'b1);
        run_op("stmdb", lsm(1, 0, 1, 1, 0, 4'd13, 16'h40F0), 32'h2000, 0, 1'b1, 32'h1FEC, 8, 1'b0);

        // LDMIB R2,{R0,R15} with two wait cycles per beat
        push(32'h0304, 4'd0, 1'b0); push(32'h0308, 4'd15, 1'b0);
        run_op("ldmib", lsm(1, 1, 1, 0, 1, 4'd2, 16'h8001), 32'h0300, 2, 1'b0, 32'h0, 8, 1'b0);

        // Empty list with W=1
        run_op("empty", lsm(0, 1, 0, 1, 1, 4'd5, 16'h0000), 32'h0700, 0, 1'b0, 32'h0, 2, 1'b0);

        // LDMDA R3!,{R3,R5}: writeback suppressed, start while busy ignored
        push(32'h003C, 4'd3, 1'b0); push(32'h0040, 4'd5, 1'b0);
        run_op("ldmda", lsm(0, 0, 0, 1, 1, 4'd3, 16'h0028), 32'h0040, 0, 1'b0, 32'h0, 5, 1'b1);

        // STMIA R1!,{R0} at the top of the address space: base wraps to 0
        push(32'hFFFF_FFFC, 4'd0, 1'b1);
        run_op("wrap", lsm(0, 1, 0, 1, 0, 4'd1, 16'h0001), 32'hFFFF_FFFC, 0, 1'b1, 32'h0, 4, 1'b0);

        // Reset during the 2nd beat of STMIA R0,{R1-R4}
        @(negedge clk);
        start = 1'b1; instr = lsm(0, 1, 0, 0, 0, 4'd0, 16'h001E); base_val = 32'h0500;
        mem_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("abort_pre_addr", mem_addr, 32'h0504);
        chk("abort_pre_idx", 32'(rf_idx), 32'd2);
        rst_n = 1'b0; #1;
        chk("abort_req", 32'(mem_req), 32'h0);
        chk("abort_we", 32'(mem_we), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_idx", 32'(rf_idx), 32'h0);
        chk("abort_rf_we", 32'(rf_we), 32'h0);
        @(negedge clk); #1;
        chk("abort_hold_req", 32'(mem_req), 32'h0);
        rst_n = 1'b1; mem_ready = 1'b0;

        push(32'h1000, 4'd1, 1'b0); push(32'h1004, 4'd2, 1'b0); push(32'h1008, 4'd4, 1'b0);
        run_op("after_rst", lsm(0, 1, 0, 1, 1, 4'd0, 16'h0016), 32'h1000, 0, 1'b1, 32'h100C, 6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
